// File: rtl/fft_frame_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the FFT frame sequencer.
// Imported by the sequencer top and its address generator.
package fft_frame_sequencer_pkg;

  localparam int N        = 16;
  localparam int STAGES   = 4;
  localparam int BFLY_LAT = 2;

  localparam int AW = STAGES;
  localparam int KW = STAGES - 1;
  localparam int SW = 2;
  localparam int DW = $clog2(BFLY_LAT + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_UNLOAD  = 3'd4
  } state_t;

  function automatic logic [AW-1:0] bitrev(
    input logic [AW-1:0] x
  );
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < AW; i++)
      r[i] = x[AW-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_sequencer_addr_gen.sv
// Butterfly address generator: (stage, k) -> top/bottom RAM address, twiddle.
// Ports: i_stage, i_k in; o_rd_a, o_rd_b, o_tw out. Purely combinational.
module fft_frame_sequencer_addr_gen
  import fft_frame_sequencer_pkg::*;
(
  input  logic [SW-1:0] i_stage,
  input  logic [KW-1:0] i_k,
  output logic [AW-1:0] o_rd_a,
  output logic [AW-1:0] o_rd_b,
  output logic [KW-1:0] o_tw
);

  logic [AW-1:0] half;
  logic [AW-1:0] mask;
  logic [AW-1:0] kx;
  logic [AW-1:0] low;
  logic [AW-1:0] twx;

  // half is a power of two, so k/half and k%half reduce to masks:
  // (k/half)*2*half == (k & ~mask) << 1.
  always_comb begin
    kx     = AW'(i_k);
    half   = AW'(N / 2) >> i_stage;
    mask   = half - AW'(1);
    low    = kx & mask;
    o_rd_a = ((kx & ~mask) << 1) | low;
    o_rd_b = o_rd_a | half;
    twx    = low << i_stage;
    o_tw   = twx[KW-1:0];
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame scheduler for the 16-point radix-2 DIF FFT: load, per-stage
// butterfly issue with delayed write-back, drain, bit-reversed unload.
// Ports: i_clk/i_rst; load i_in_valid/o_in_ready; RAM o_wr_*, o_rd_*;
// o_tw_addr, o_bfly_valid, o_stage; unload i_out_ready/o_out_valid/
// o_out_last; status o_frame_done, o_busy.
module fft_frame_sequencer
  import fft_frame_sequencer_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr_a,
  output logic [AW-1:0] o_wr_addr_b,
  output logic [AW-1:0] o_rd_addr_a,
  output logic [AW-1:0] o_rd_addr_b,
  output logic [KW-1:0] o_tw_addr,
  output logic          o_bfly_valid,
  output logic [SW-1:0] o_stage,
  input  logic          i_out_ready,
  output logic          o_out_valid,
  output logic          o_out_last,
  output logic          o_frame_done,
  output logic          o_busy
);

  state_t        state;
  logic [AW-1:0] cnt;
  logic [KW-1:0] k;
  logic [SW-1:0] stage;
  logic [DW-1:0] dcnt;

  logic [AW-1:0] ag_a;
  logic [AW-1:0] ag_b;
  logic [KW-1:0] ag_tw;

  logic          wb_v [BFLY_LAT];
  logic [AW-1:0] wb_a [BFLY_LAT];
  logic [AW-1:0] wb_b [BFLY_LAT];

  logic          load_wr;
  logic          wb_en;

  fft_frame_sequencer_addr_gen u_addr_gen (
    .i_stage (stage),
    .i_k     (k),
    .o_rd_a  (ag_a),
    .o_rd_b  (ag_b),
    .o_tw    (ag_tw)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      k            <= '0;
      stage        <= '0;
      dcnt         <= '0;
      o_in_ready   <= 1'b0;
      o_bfly_valid <= 1'b0;
      o_out_valid  <= 1'b0;
      o_frame_done <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          state      <= ST_LOAD;
          cnt        <= '0;
          o_in_ready <= 1'b1;
          o_busy     <= 1'b1;
        end
        ST_LOAD: begin
          if (i_in_valid) begin
            if (cnt == AW'(N - 1)) begin
              state        <= ST_COMPUTE;
              cnt          <= '0;
              k            <= '0;
              stage        <= '0;
              o_in_ready   <= 1'b0;
              o_bfly_valid <= 1'b1;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end
        ST_COMPUTE: begin
          if (k == KW'(N / 2 - 1)) begin
            state        <= ST_DRAIN;
            k            <= '0;
            dcnt         <= '0;
            o_bfly_valid <= 1'b0;
          end else begin
            k <= k + KW'(1);
          end
        end
        ST_DRAIN: begin
          if (dcnt == DW'(BFLY_LAT - 1)) begin
            dcnt <= '0;
            if (stage == SW'(STAGES - 1)) begin
              state       <= ST_UNLOAD;
              stage       <= '0;
              cnt         <= '0;
              o_out_valid <= 1'b1;
            end else begin
              state        <= ST_COMPUTE;
              stage        <= stage + SW'(1);
              k            <= '0;
              o_bfly_valid <= 1'b1;
            end
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        ST_UNLOAD: begin
          if (i_out_ready) begin
            if (cnt == AW'(N - 1)) begin
              state        <= ST_IDLE;
              cnt          <= '0;
              o_out_valid  <= 1'b0;
              o_frame_done <= 1'b1;
              o_busy       <= 1'b0;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end
        default: begin
          state        <= ST_IDLE;
          cnt          <= '0;
          k            <= '0;
          stage        <= '0;
          dcnt         <= '0;
          o_in_ready   <= 1'b0;
          o_bfly_valid <= 1'b0;
          o_out_valid  <= 1'b0;
          o_busy       <= 1'b0;
        end
      endcase
    end
  end

  // Read side: butterfly addresses while issuing, bit-reversed
  // unload address while streaming out, zero otherwise.
  always_comb begin
    o_rd_addr_a = '0;
    o_rd_addr_b = '0;
    o_tw_addr   = '0;
    if (o_bfly_valid) begin
      o_rd_addr_a = ag_a;
      o_rd_addr_b = ag_b;
      o_tw_addr   = ag_tw;
    end else if (o_out_valid) begin
      o_rd_addr_a = bitrev(cnt);
    end
  end

  // Write-back delay line matches the butterfly pipeline depth.
  // Reset clears it so an abandoned frame issues no late writes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < BFLY_LAT; i++) begin
        wb_v[i] <= 1'b0;
        wb_a[i] <= '0;
        wb_b[i] <= '0;
      end
    end else begin
      wb_v[0] <= o_bfly_valid;
      wb_a[0] <= o_rd_addr_a;
      wb_b[0] <= o_rd_addr_b;
      for (int i = 1; i < BFLY_LAT; i++) begin
        wb_v[i] <= wb_v[i-1];
        wb_a[i] <= wb_a[i-1];
        wb_b[i] <= wb_b[i-1];
      end
    end
  end

  // Load writes are strobed in the handshake cycle so the RAM
  // captures the sample presented alongside i_in_valid.
  assign load_wr = o_in_ready & i_in_valid;
  assign wb_en   = wb_v[BFLY_LAT-1];
  assign o_wr_en = load_wr | wb_en;

  always_comb begin
    o_wr_addr_a = '0;
    o_wr_addr_b = '0;
    if (load_wr) begin
      o_wr_addr_a = cnt;
    end else if (wb_en) begin
      o_wr_addr_a = wb_a[BFLY_LAT-1];
      o_wr_addr_b = wb_b[BFLY_LAT-1];
    end
  end

  assign o_stage    = stage;
  assign o_out_last = o_out_valid & (cnt == AW'(N - 1));

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer: load, butterfly schedule,
// write-back alignment, bit-reversed unload, handshake stalls, reset.
module tb_fft_frame_sequencer;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_in_valid;
  logic       o_in_ready;
  logic       o_wr_en;
  logic [3:0] o_wr_addr_a;
  logic [3:0] o_wr_addr_b;
  logic [3:0] o_rd_addr_a;
  logic [3:0] o_rd_addr_b;
  logic [2:0] o_tw_addr;
  logic       o_bfly_valid;
  logic [1:0] o_stage;
  logic       i_out_ready;
  logic       o_out_valid;
  logic       o_out_last;
  logic       o_frame_done;
  logic       o_busy;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  fft_frame_sequencer dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .o_wr_en      (o_wr_en),
    .o_wr_addr_a  (o_wr_addr_a),
    .o_wr_addr_b  (o_wr_addr_b),
    .o_rd_addr_a  (o_rd_addr_a),
    .o_rd_addr_b  (o_rd_addr_b),
    .o_tw_addr    (o_tw_addr),
    .o_bfly_valid (o_bfly_valid),
    .o_stage      (o_stage),
    .i_out_ready  (i_out_ready),
    .o_out_valid  (o_out_valid),
    .o_out_last   (o_out_last),
    .o_frame_done (o_frame_done),
    .o_busy       (o_busy)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Reference schedule written directly from the index formulas.
  task automatic model(
    input  int s,
    input  int kk,
    output int a,
    output int b,
    output int t
  );
    int half;
    half = 8 >> s;
    a = (kk / half) * 2 * half + kk % half;
    b = a + half;
    t = (kk % half) << s;
  endtask

  function automatic int brev(input int x);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++)
      if (x[i]) r = r | (8 >> i);
    return r;
  endfunction

  task automatic all_zero(input string tag);
    chk({tag, "_in_ready"},   o_in_ready, 0);
    chk({tag, "_wr_en"},      o_wr_en, 0);
    chk({tag, "_wr_a"},       o_wr_addr_a, 0);
    chk({tag, "_wr_b"},       o_wr_addr_b, 0);
    chk({tag, "_rd_a"},       o_rd_addr_a, 0);
    chk({tag, "_rd_b"},       o_rd_addr_b, 0);
    chk({tag, "_tw"},         o_tw_addr, 0);
    chk({tag, "_bfly_valid"}, o_bfly_valid, 0);
    chk({tag, "_stage"},      o_stage, 0);
    chk({tag, "_out_valid"},  o_out_valid, 0);
    chk({tag, "_out_last"},   o_out_last, 0);
    chk({tag, "_frame_done"}, o_frame_done, 0);
    chk({tag, "_busy"},       o_busy, 0);
  endtask

  task automatic load(input bit gaps);
    int n;
    n = 0;
    for (int c = 0; c < 200 && n < 16; c++) begin
      @(negedge i_clk);
      i_in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (i_in_valid && o_in_ready) begin
        chk("ld_wr_en", o_wr_en, 1);
        chk("ld_wr_addr", o_wr_addr_a, n);
        chk("ld_busy", o_busy, 1);
        n++;
      end else if (o_in_ready) begin
        chk("ld_gap_wr_en", o_wr_en, 0);
      end
    end
    chk("ld_count", n, 16);
    @(posedge i_clk);
    #1 i_in_valid = 1'b0;
  endtask

  // Checks every compute/drain cycle: reads against the model and
  // write-backs against reads remembered two cycles earlier.
  task automatic compute_all();
    int pv[2];
    int pa[2];
    int pb[2];
    int a, b, t;
    pv = '{0, 0};
    pa = '{0, 0};
    pb = '{0, 0};
    for (int s = 0; s < 4; s++) begin
      for (int step = 0; step < 10; step++) begin
        @(negedge i_clk);
        #1;
        chk("cp_in_ready", o_in_ready, 0);
        chk("cp_stage", o_stage, s);
        chk("cp_bfly_valid", o_bfly_valid, step < 8);
        a = 0; b = 0; t = 0;
        if (step < 8) begin
          model(s, step, a, b, t);
          chk("cp_rd_a", o_rd_addr_a, a);
          chk("cp_rd_b", o_rd_addr_b, b);
          chk("cp_tw", o_tw_addr, t);
        end
        chk("wb_en", o_wr_en, pv[1]);
        if (pv[1] != 0) begin
          chk("wb_addr_a", o_wr_addr_a, pa[1]);
          chk("wb_addr_b", o_wr_addr_b, pb[1]);
        end
        pv[1] = pv[0]; pa[1] = pa[0]; pb[1] = pb[0];
        pv[0] = (step < 8) ? 1 : 0;
        pa[0] = a; pb[0] = b;
      end
    end
  endtask

  task automatic unload(input bit rnd);
    int idx;
    idx = 0;
    for (int c = 0; c < 300 && idx < 16; c++) begin
      @(negedge i_clk);
      i_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("ul_valid", o_out_valid, 1);
      chk("ul_addr", o_rd_addr_a, brev(idx));
      chk("ul_last", o_out_last, idx == 15);
      chk("ul_wr_en", o_wr_en, 0);
      if (i_out_ready) idx++;
    end
    chk("ul_count", idx, 16);
    @(posedge i_clk);
    #1 i_out_ready = 1'b0;
    @(negedge i_clk);
    chk("done_pulse", o_frame_done, 1);
    chk("done_busy", o_busy, 0);
    chk("done_valid", o_out_valid, 0);
    @(negedge i_clk);
    chk("done_clear", o_frame_done, 0);
    chk("reload_ready", o_in_ready, 1);
    chk("reload_busy", o_busy, 1);
  endtask

  initial begin
    int c;
    i_rst       = 1'b1;
    i_in_valid  = 1'b0;
    i_out_ready = 1'b0;
    @(negedge i_clk);
    all_zero("rst");
    @(negedge i_clk);
    i_rst = 1'b0;

    load(1'b0);
    compute_all();
    unload(1'b0);

    load(1'b1);
    compute_all();
    unload(1'b1);

    load(1'b0);
    for (c = 0; c < 100; c++) begin
      @(negedge i_clk);
      if (o_stage == 2'd2 && o_bfly_valid) break;
    end
    chk("reach_stage2", c < 100, 1);
    #2 i_rst = 1'b1;
    #1;
    all_zero("midrst");
    @(negedge i_clk);
    all_zero("midrst_hold");
    i_rst = 1'b0;

    load(1'b0);
    compute_all();
    unload(1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
